// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Packet-level round-robin arbiter sharing one UART transmitter
//             byte interface between NUM_REQ byte-stream requesters. Each
//             grant can be prefixed with a channel-ID header {4'hA, id}.
//             A grant is forcibly released after MAX_PKT data bytes; the
//             rest of that packet then competes again as a new grant.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             req_vld/req_data/req_last/req_rdy - per-requester byte streams
//             tx_data/tx_vld/tx_rdy             - transmitter byte interface
//             grant         - registered one-hot grant, zero when idle
//             busy          - high while a grant is active (HDR or DATA)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int HDR_EN  = 1,
    parameter int MAX_PKT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_vld,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic [7:0]             tx_data,
    output logic                   tx_vld,
    input  logic                   tx_rdy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam logic [7:0]         c_max_pkt  = 8'(MAX_PKT);
    localparam logic [3:0]         c_last_idx = 4'(NUM_REQ - 1);
    localparam logic [4:0]         c_num_req  = 5'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         id_q, id_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;

    logic               w_sel_vld;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_any;
    logic [3:0]         w_win;
    logic [4:0]         w_cand;
    logic [7:0]         w_cnt_inc;

    // Stream of the currently granted requester.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id_q == 4'(i)) begin
                w_sel_vld  = req_vld[i];
                w_sel_last = req_last[i];
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin search: candidates ptr, ptr+1, ... (mod NUM_REQ); the
    // first valid one wins. A 5-bit sum keeps the wrap exact up to 16.
    always_comb begin
        w_any  = 1'b0;
        w_win  = 4'd0;
        w_cand = 5'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_q} + 5'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_any && (w_cand[3:0] == 4'(i)) && req_vld[i]) begin
                    w_any = 1'b1;
                    w_win = 4'(i);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        tx_vld     = 1'b0;
        tx_data    = 8'h00;
        req_rdy    = '0;
        w_cnt_inc  = byte_cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    grant_d    = c_one << w_win;
                    id_d       = w_win;
                    ptr_d      = (w_win == c_last_idx) ? 4'd0 : w_win + 4'd1;
                    byte_cnt_d = 8'd0;
                    state_d    = (HDR_EN != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                tx_vld  = 1'b1;
                tx_data = {4'hA, id_q};
                if (tx_rdy) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Pass-through: the requester sees the transmitter's ready
                // directly, so an accept is a single combinational handshake.
                tx_vld  = w_sel_vld;
                tx_data = w_sel_data;
                req_rdy = grant_q & {NUM_REQ{tx_rdy}};
                if (w_sel_vld && tx_rdy) begin
                    byte_cnt_d = w_cnt_inc;
                    // End of packet and the byte limit coinciding is still a
                    // single release.
                    if (w_sel_last || (w_cnt_inc == c_max_pkt)) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            id_q       <= 4'd0;
            ptr_q      <= 4'd0;
            byte_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares one UART transmitter byte interface between NUM_REQ independent byte-stream requesters. It sits between the client logic and the UART transmitter. Each granted packet can optionally be prefixed with a channel-ID header byte, so the remote end can demultiplex streams. A byte-count limit bounds how long one requester may hold the line.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- HDR_EN, 1: 1 = emit header byte {4'hA, id[3:0]} before each grant's data; 0 = no header.
- MAX_PKT, 64: maximum data bytes per grant; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_vld  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_rdy  out  NUM_REQ  byte accepted when req_vld[i] && req_rdy[i].
- tx_data  out  8  byte to the transmitter.
- tx_vld  out  1  byte valid to the transmitter.
- tx_rdy  in  1  transmitter accepts a byte when tx_vld && tx_rdy.
- grant  out  NUM_REQ  one-hot registered grant; all zero when idle.
- busy  out  1  high in HDR or DATA.

## Operation
- FSM with states IDLE, HDR, DATA.
- IDLE:
  - If any req_vld is high, select a winner by round-robin starting at ptr.
  - Register the one-hot grant, the winner id and byte_cnt = 0.
  - Go to HDR if HDR_EN = 1, otherwise go to DATA.
  - If no req_vld is high, stay in IDLE.
- ptr rules:
  - ptr is the index after the last winner, mod NUM_REQ.
  - Reset value is 0, so requester 0 has highest priority first.
  - ptr updates when the grant is issued.
- HDR:
  - tx_vld = 1, tx_data = {4'hA, id}, req_rdy = 0.
  - On tx_rdy, go to DATA.
- DATA (pass-through, combinational from the granted requester):
  - tx_vld = req_vld[id], tx_data = req_data[id].
  - req_rdy[id] = tx_rdy; all other req_rdy bits are 0.
  - Each accepted byte increments byte_cnt.
  - Release to IDLE, clearing grant, on an accepted byte with req_last[id] = 1, or on the accepted byte that makes byte_cnt reach MAX_PKT.
- Forced release at MAX_PKT:
  - The remainder of the packet competes again as a new grant.
  - It gets a new header when HDR_EN = 1.
  - req_last is not required at the split point.
- Requester stall in DATA (req_vld[id] low): hold the grant indefinitely. tx_vld is 0 while stalled; there is no timeout.
- IDLE outputs: tx_vld = 0, tx_data = 8'h00, req_rdy = 0.
- Arithmetic: byte_cnt is 8 bits; the compare is byte_cnt + 1 == MAX_PKT on accept. id is 4 bits wide.
- Non-granted requesters are never backpressured into dropping; they simply wait with req_rdy = 0.

## Timing
- Reset values: grant = 0, busy = 0, tx_vld = 0, tx_data = 8'h00, req_rdy = 0, state = IDLE, ptr = 0, byte_cnt = 0.
- Reset mid-packet: return to IDLE on the next edge. The partially sent packet is abandoned with no flush and no trailing header.
- Grant latency: req_vld seen in IDLE at cycle n gives grant/busy high at n+1. The header (or first data byte) is presented at n+1.
- Re-arbitration: at least one IDLE cycle between grants. Back-to-back packets from one requester therefore have a 1-cycle tx_vld gap.
- Peak rate: one byte per cycle when tx_rdy stays high. In real use, tx_rdy is throttled by the transmitter.
- Simultaneous events:
  - A requester raising req_vld in the release cycle is not seen until the IDLE cycle.
  - req_last together with byte_cnt reaching MAX_PKT counts as a single release; the next packet starts fresh.
- The grant is stable for the full HDR+DATA duration. req_vld changes on other channels have no effect.

## Test plan
- Single packet: NUM_REQ = 4, HDR_EN = 1. Requester 2 sends 0x11, 0x22, 0x33 (last on 0x33), tx_rdy = 1. Expect tx bytes A2, 11, 22, 33; grant = 4'b0100 for exactly 4 cycles; then IDLE with busy = 0.
- Fairness: all 4 requesters continuously send 1-byte packets. Expect header sequence A0, A1, A2, A3, A0, … with no requester skipped and one IDLE cycle between grants.
- MAX_PKT split: MAX_PKT = 4. Requester 1 sends a 6-byte packet while requester 3 is also requesting. Expect A1 + 4 bytes, then A3 + its packet, then A1 + the remaining 2 bytes.
- Backpressure: toggle tx_rdy every 3 cycles and stall req_vld mid-packet. Expect no byte lost or duplicated, data order preserved, grant held through the stall.
- Reset mid-packet: assert rst during the 2nd data byte. Next cycle: grant = 0, tx_vld = 0, req_rdy = 0. The next arbitration starts from requester 0.
- HDR_EN = 0: requester 0 sends 0xAA, 0x55. Expect tx bytes AA, 55 only, with the first byte on the cycle after grant.
